syndrome_round_assembler: RTL and testbench
===========================================

// Module: syndrome_round_assembler
// PURPOSE
//   Consumes narrow syndrome beats from the upstream FWFT FIFO stage and packs NUM_BEATS beats
//   into one wide measurement-round word for the decoder front end. Sits directly downstream of
//   the FIFO wrapper (FIFO WIDTH = IN_WIDTH+1, {last, data}, last in MSB).
//   Ready/valid on both sides. Partial rounds are terminated by in_last.
// PARAMETERS
//   IN_WIDTH    4   bits per input beat
//   NUM_BEATS   8   beats per full round; >=2
//   ROUND_ID_W  16  round-id counter width (used only with ROUND_ID_EN)
//   localparams: OUT_WIDTH = IN_WIDTH*NUM_BEATS; CNT_W = $clog2(NUM_BEATS+1)
// PORTS
//   clk           in   1          clock
//   srst          in   1          synchronous reset, active-high
//   in_valid      in   1          upstream beat valid (FIFO !empty)
//   in_ready      out  1          beat accepted when in_valid && in_ready (drives FIFO rd_en)
//   in_data       in   IN_WIDTH   beat payload
//   in_last       in   1          beat is final beat of a (possibly short) round
//   out_valid     out  1          assembled round available
//   out_ready     in   1          downstream accepts round when out_valid && out_ready
//   out_data      out  OUT_WIDTH  assembled round; beat k at [k*IN_WIDTH +: IN_WIDTH]
//   out_beats     out  CNT_W      number of valid beats in out_data (1..NUM_BEATS)
//   out_round_id  out  ROUND_ID_W only with ROUND_ID_EN: sequence number of current round
// BEHAVIOUR
//   - Reset (srst=1 at posedge): out_valid=0, out_data=0, out_beats=0, accumulator=0,
//     beat_cnt=0, out_round_id=0. in_ready forced 0 while srst is high.
//   - Datapath: accumulator reg + beat_cnt; separate output register (out_data/out_beats/out_valid).
//   - in_ready = !srst && (!out_valid || out_ready); combinational, never depends on in_valid.
//   - Accepted beat written into accumulator slot beat_cnt; beat_cnt increments.
//   - Round completes on accepted beat with beat_cnt==NUM_BEATS-1 or in_last=1:
//     accumulator+beat copied to output register next edge, unfilled beat slots zero,
//     out_beats = beat_cnt+1; accumulator and beat_cnt cleared same edge.
//   - Latency: completing beat accepted at edge t -> out_valid=1 after edge t (visible cycle t+1).
//   - in_last on beat NUM_BEATS-1 is a normal full round (out_beats=NUM_BEATS).
//   - Output handshake and new completion on same edge: output reg overwritten, out_valid stays 1.
//   - Output handshake without completion: out_valid -> 0.
//   - While out_valid && !out_ready: out_data/out_beats/out_round_id held stable, in_ready=0.
//   - Sustained throughput 1 beat/cycle when out_ready held high; no bubbles at round boundary.
//   - srst mid-round: partial accumulator discarded, pending output dropped, no output emitted.
// CONFIGURATION
//   `define ROUND_ID_EN: out_round_id port present; counter increments on each output handshake,
//     wraps modulo 2^ROUND_ID_W; value presented equals count of rounds previously handed off.
//   Without ROUND_ID_EN: port and counter absent; all other behaviour identical.
// STRUCTURE
//   - Shared package helios_stream_pkg: beat-slot index helper, {last,data} FIFO-word pack/unpack
//     constants (LAST_BIT = IN_WIDTH), CNT_W computation function.
//   - Single module; no sub-module (accumulator, counter, output reg are too small to split).
// TESTING (IN_WIDTH=4, NUM_BEATS=4 unless noted)
//   1. Beats 1,2,3,4 back-to-back, out_ready=1 -> out_data=16'h4321, out_beats=4, out_valid one cycle.
//   2. Beats A,B with in_last on B -> out_data=16'h00BA, out_beats=2; next round starts at slot 0.
//   3. Round complete, out_ready=0 for 10 cycles -> in_ready=0, out_data stable; out_ready=1 ->
//      handshake and next beat accepted same edge.
//   4. 3 rounds streamed, out_ready=1, in_valid=1 -> in_ready never low, one round per 4 cycles.
//   5. srst after beats 7,8 -> out_valid=0; then 5,6,7,8 -> out_data=16'h8765, no stale data.
//   6. ROUND_ID_EN, ROUND_ID_W=2: 5 rounds -> out_round_id 0,1,2,3,0.

Source files
------------

// File: rtl/helios_stream_pkg.sv
// Shared stream helpers: FIFO word layout {last, data}, beat-slot indexing and counter sizing.
package helios_stream_pkg;

  localparam int DEF_IN_WIDTH = 4;
  // The FIFO word carries the last flag directly above the payload.
  localparam int LAST_BIT     = DEF_IN_WIDTH;
  localparam int FIFO_WIDTH   = DEF_IN_WIDTH + 1;

  function automatic int cnt_width(input int num_beats);
    return $clog2(num_beats + 1);
  endfunction

  function automatic int slot_lsb(input int slot, input int in_width);
    return slot * in_width;
  endfunction

  function automatic logic fifo_last(input logic [FIFO_WIDTH-1:0] word);
    return word[LAST_BIT];
  endfunction

  function automatic logic [DEF_IN_WIDTH-1:0] fifo_data(input logic [FIFO_WIDTH-1:0] word);
    return word[DEF_IN_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/syndrome_round_assembler.sv
// Packs NUM_BEATS narrow syndrome beats (or fewer, ended by in_last) into one round word.
// Optional `define ROUND_ID_EN adds out_round_id, a count of rounds already handed off.
module syndrome_round_assembler
  import helios_stream_pkg::*;
#(
  parameter  int IN_WIDTH   = 4,
  parameter  int NUM_BEATS  = 8,
  parameter  int ROUND_ID_W = 16,
  localparam int OUT_WIDTH  = IN_WIDTH * NUM_BEATS,
  localparam int CNT_W      = cnt_width(NUM_BEATS)
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic [CNT_W-1:0]      out_beats
`ifdef ROUND_ID_EN
  ,
  output logic [ROUND_ID_W-1:0] out_round_id
`endif
);

  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]     out_beats_q, out_beats_d;
  logic                 out_valid_q, out_valid_d;

  logic                 accept;
  logic                 complete;
  logic                 handoff;
  logic [OUT_WIDTH-1:0] merged;

  // Ready is purely a function of output-register occupancy so upstream can't form a loop.
  assign in_ready = !srst && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid_q && out_ready;
  assign complete = accept && (in_last || (beat_cnt_q == CNT_W'(NUM_BEATS - 1)));

  // Slots above beat_cnt are always zero because the accumulator clears on completion.
  always_comb begin
    merged = acc_q;
    for (int k = 0; k < NUM_BEATS; k++) begin
      if (beat_cnt_q == CNT_W'(k)) merged[slot_lsb(k, IN_WIDTH) +: IN_WIDTH] = in_data;
    end
  end

  always_comb begin
    acc_d       = acc_q;
    beat_cnt_d  = beat_cnt_q;
    out_data_d  = out_data_q;
    out_beats_d = out_beats_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      acc_d      = merged;
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end
    if (complete) begin
      acc_d       = '0;
      beat_cnt_d  = '0;
      out_data_d  = merged;
      out_beats_d = beat_cnt_q + CNT_W'(1);
      out_valid_d = 1'b1;
    end else if (handoff) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      acc_q       <= '0;
      beat_cnt_q  <= '0;
      out_data_q  <= '0;
      out_beats_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      beat_cnt_q  <= beat_cnt_d;
      out_data_q  <= out_data_d;
      out_beats_q <= out_beats_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_beats = out_beats_q;
  assign out_valid = out_valid_q;

`ifdef ROUND_ID_EN
  logic [ROUND_ID_W-1:0] round_id_q, round_id_d;

  // Wraps naturally at 2^ROUND_ID_W.
  always_comb begin
    round_id_d = round_id_q;
    if (handoff) round_id_d = round_id_q + ROUND_ID_W'(1);
  end

  always_ff @(posedge clk) begin
    if (srst) round_id_q <= '0;
    else      round_id_q <= round_id_d;
  end

  assign out_round_id = round_id_q;
`endif

endmodule

// File: tb/tb_syndrome_round_assembler.sv
// Directed + random bench for syndrome_round_assembler (IN_WIDTH=4, NUM_BEATS=4).
module tb_syndrome_round_assembler;

  localparam int IW  = 4;
  localparam int NB  = 4;
  localparam int OW  = IW * NB;
  localparam int CW  = $clog2(NB + 1);
  localparam int RIW = 2;

  logic          clk = 1'b0;
  logic          srst;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [CW-1:0] out_beats;
`ifdef ROUND_ID_EN
  logic [RIW-1:0] out_round_id;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: output register contents plus the beats of the round in progress.
  int          cur[$];
  bit          m_valid;
  int unsigned m_data;
  int          m_beats;
  int          m_id;

  always #5 clk = ~clk;

  syndrome_round_assembler #(
    .IN_WIDTH(IW), .NUM_BEATS(NB), .ROUND_ID_W(RIW)
  ) dut (
    .clk(clk), .srst(srst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_beats(out_beats)
`ifdef ROUND_ID_EN
    , .out_round_id(out_round_id)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned pack_round(input int q[$]);
    int unsigned w = 0;
    for (int k = 0; k < q.size(); k++) w += (q[k] & 15) << (IW * k);
    return w;
  endfunction

  // One clock: advance the model with pre-edge inputs, then compare just after the edge.
  task automatic tick();
    bit rdy, hs, acc, done;
    @(posedge clk);
    if (srst) begin
      m_valid = 0; m_data = 0; m_beats = 0; m_id = 0;
      cur.delete();
    end else begin
      rdy  = !m_valid || out_ready;
      hs   = m_valid && out_ready;
      acc  = in_valid && rdy;
      done = 0;
      if (hs) m_id = (m_id + 1) % (1 << RIW);
      if (acc) begin
        cur.push_back(int'(in_data));
        if (in_last || cur.size() == NB) begin
          m_data  = pack_round(cur);
          m_beats = cur.size();
          m_valid = 1;
          done    = 1;
          cur.delete();
        end
      end
      if (!done && hs) m_valid = 0;
    end
    #1;
    chk("in_ready",  64'(in_ready),  64'(!srst && (!m_valid || out_ready)));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_data",  64'(out_data),  64'(m_data));
    chk("out_beats", 64'(out_beats), 64'(m_beats));
`ifdef ROUND_ID_EN
    chk("round_id",  64'(out_round_id), 64'(m_id));
`endif
  endtask

  task automatic drive(input bit v, input int d, input bit l, input bit r);
    in_valid  = v;
    in_data   = IW'(d);
    in_last   = l;
    out_ready = r;
    tick();
  endtask

  int lows, rounds;

  initial begin
    srst = 1; in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
    m_valid = 0; m_data = 0; m_beats = 0; m_id = 0;
    tick(); tick();
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    srst = 0;

    // 1: full round back-to-back
    drive(1, 1, 0, 1); drive(1, 2, 0, 1); drive(1, 3, 0, 1); drive(1, 4, 0, 1);
    chk("t1_data", 64'(out_data), 64'h4321);
    chk("t1_beats", 64'(out_beats), 64'd4);
    drive(0, 0, 0, 1);
    chk("t1_pulse", 64'(out_valid), 64'd0);

    // 2: short round, then next round restarts at slot 0
    drive(1, 'hA, 0, 1); drive(1, 'hB, 1, 1);
    chk("t2_data", 64'(out_data), 64'h00BA);
    chk("t2_beats", 64'(out_beats), 64'd2);
    drive(1, 1, 0, 1); drive(1, 2, 0, 1); drive(1, 3, 0, 1); drive(1, 4, 0, 1);
    chk("t2_next", 64'(out_data), 64'h4321);

    // 3: backpressure holds the round and stalls input
    drive(1, 1, 0, 0); drive(1, 2, 0, 0); drive(1, 3, 0, 0); drive(1, 4, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 5, 0, 0);
      chk("t3_stall", 64'(in_ready), 64'd0);
      chk("t3_hold", 64'(out_data), 64'h4321);
    end
    drive(1, 5, 0, 1); drive(1, 6, 0, 1); drive(1, 7, 0, 1); drive(1, 8, 0, 1);
    chk("t3_next", 64'(out_data), 64'h8765);

    // 4: three streamed rounds, no bubbles
    lows = 0; rounds = 0;
    for (int i = 0; i < 3 * NB; i++) begin
      if (!in_ready) lows++;
      drive(1, i + 1, 0, 1);
      if (out_valid) rounds++;
    end
    chk("t4_lows", 64'(lows), 64'd0);
    chk("t4_rounds", 64'(rounds), 64'd3);
    drive(0, 0, 0, 1);

    // 5: reset mid-round discards partial beats
    drive(1, 7, 0, 1); drive(1, 8, 0, 1);
    srst = 1; drive(0, 0, 0, 1); srst = 0;
    chk("t5_valid", 64'(out_valid), 64'd0);
    drive(1, 5, 0, 1); drive(1, 6, 0, 1); drive(1, 7, 0, 1); drive(1, 8, 0, 1);
    chk("t5_data", 64'(out_data), 64'h8765);
    drive(0, 0, 0, 1);

    // Random traffic with occasional short rounds, stalls and resets
    for (int i = 0; i < 600; i++) begin
      srst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
            $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
    end
    srst = 0;
    drive(0, 0, 0, 1); drive(0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
